// File: rtl/parking_lot_monitor.sv
// Multi-lane parking lot monitor: per-gate sensor debounce and direction FSM,
// feeding a shared occupancy counter clamped to the lot capacity.
module parking_lot_monitor #(
    parameter int N_LANES  = 2,
    parameter int CAP      = 25,
    parameter int DEBOUNCE = 2,
    localparam int CNT_W   = $clog2(CAP + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_LANES-1:0]     outer,
    input  logic [N_LANES-1:0]     inner,
    input  logic                   clear,
    output logic [N_LANES-1:0]     enter,
    output logic [N_LANES-1:0]     exit,
    output logic [N_LANES-1:0]     seq_err,
    output logic [CNT_W-1:0]       count,
    output logic                   full,
    output logic                   empty,
    output logic                   ovf,
    output logic                   unf,
    output logic [3*N_LANES-1:0]   lane_state
);

    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int SW = CNT_W + $clog2(N_LANES) + 2;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] EA   = 3'd1;
    localparam logic [2:0] EB   = 3'd2;
    localparam logic [2:0] EC   = 3'd3;
    localparam logic [2:0] XA   = 3'd4;
    localparam logic [2:0] XB   = 3'd5;
    localparam logic [2:0] XC   = 3'd6;
    localparam logic [2:0] ERR  = 3'd7;

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        logic [1:0]    sync1, sync2, filt;
        logic [DW-1:0] stab;
        logic [2:0]    state, state_nx;
        logic          ent_nx, ext_nx, err_nx;
        logic          ent_q, ext_q, err_q;

        // sync1 is one cycle ahead of sync2, so a disagreement means sync2 is about to change
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync1 <= 2'b00;
                sync2 <= 2'b00;
                filt  <= 2'b00;
                stab  <= '0;
            end else begin
                sync1 <= {outer[g], inner[g]};
                sync2 <= sync1;
                if (sync2 != filt && stab == DW'(DEBOUNCE - 1)) begin
                    filt <= sync2;
                    stab <= '0;
                end else if (sync2 == filt || sync1 != sync2) begin
                    stab <= '0;
                end else begin
                    stab <= stab + DW'(1);
                end
            end
        end

        always_comb begin
            state_nx = state;
            ent_nx   = 1'b0;
            ext_nx   = 1'b0;
            case (state)
                IDLE: case (filt)
                    2'b10:   state_nx = EA;
                    2'b01:   state_nx = XA;
                    2'b11:   state_nx = ERR;
                    default: ;
                endcase
                EA: case (filt)
                    2'b11:   state_nx = EB;
                    2'b00:   state_nx = IDLE;
                    2'b01:   state_nx = ERR;
                    default: ;
                endcase
                EB: case (filt)
                    2'b01:   state_nx = EC;
                    2'b10:   state_nx = EA;
                    2'b00:   state_nx = ERR;
                    default: ;
                endcase
                EC: case (filt)
                    2'b00:   begin state_nx = IDLE; ent_nx = 1'b1; end
                    2'b11:   state_nx = EB;
                    2'b10:   state_nx = ERR;
                    default: ;
                endcase
                XA: case (filt)
                    2'b11:   state_nx = XB;
                    2'b00:   state_nx = IDLE;
                    2'b10:   state_nx = ERR;
                    default: ;
                endcase
                XB: case (filt)
                    2'b10:   state_nx = XC;
                    2'b01:   state_nx = XA;
                    2'b00:   state_nx = ERR;
                    default: ;
                endcase
                XC: case (filt)
                    2'b00:   begin state_nx = IDLE; ext_nx = 1'b1; end
                    2'b11:   state_nx = XB;
                    2'b01:   state_nx = ERR;
                    default: ;
                endcase
                default: if (filt == 2'b00) state_nx = IDLE;
            endcase
            err_nx = (state_nx == ERR) && (state != ERR);
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state <= IDLE;
                ent_q <= 1'b0;
                ext_q <= 1'b0;
                err_q <= 1'b0;
            end else begin
                state <= state_nx;
                ent_q <= ent_nx;
                ext_q <= ext_nx;
                err_q <= err_nx;
            end
        end

        assign enter[g]              = ent_q;
        assign exit[g]               = ext_q;
        assign seq_err[g]            = err_q;
        assign lane_state[3*g +: 3]  = state;
    end

    localparam logic signed [SW-1:0] CAP_S = SW'(CAP);

    // Wide signed sum so a full set of simultaneous entries or exits never wraps
    logic signed [SW-1:0] sum;
    always_comb begin
        sum = $signed({{(SW - CNT_W){1'b0}}, count});
        for (int l = 0; l < N_LANES; l++) begin
            sum = sum + SW'(enter[l]) - SW'(exit[l]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (clear) begin
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (sum[SW-1]) begin
            count <= '0;
            unf   <= 1'b1;
        end else if (sum > CAP_S) begin
            count <= CNT_W'(CAP);
            ovf   <= 1'b1;
        end else begin
            count <= sum[CNT_W-1:0];
        end
    end

    assign full  = (count == CNT_W'(CAP));
    assign empty = (count == '0);

endmodule

// File: doc/parking_lot_monitor.md
# parking_lot_monitor

Multi-lane successor to the single-gate car detector. Each of `N_LANES` gates has an outer/inner photo-sensor pair. Per lane, the block synchronises and debounces the pair and runs a direction-tracking FSM that flags illegal sequences. A shared occupancy counter is clamped to `CAP` and drives full/empty/overflow indication for the lot display and gate-control logic.

## Interface
- `N_LANES`, 2, number of gates (≥1)
- `CAP`, 25, lot capacity (≥1)
- `DEBOUNCE`, 2, consecutive stable cycles needed to accept a new sensor pair (≥1)
- `CNT_W`, $clog2(CAP+1), occupancy width (derived, not overridden)

Ports:
- `clk`  in  1  single clock, all logic posedge
- `reset_n`  in  1  asynchronous, active-low reset
- `outer`  in  N_LANES  raw outer sensor per lane, 1 = blocked, asynchronous to clk
- `inner`  in  N_LANES  raw inner sensor per lane, 1 = blocked
- `clear`  in  1  synchronous; zeroes `count`, `ovf`, `unf`
- `enter`  out  N_LANES  one-cycle pulse per completed entry
- `exit`  out  N_LANES  one-cycle pulse per completed exit
- `seq_err`  out  N_LANES  one-cycle pulse on illegal transition
- `count`  out  CNT_W  current occupancy
- `full`  out  1  `count == CAP`
- `empty`  out  1  `count == 0`
- `ovf`  out  1  sticky: an entry was dropped at CAP
- `unf`  out  1  sticky: an exit was dropped at 0

## Operation
- **Per lane front end:**
  - Two-flop synchroniser on the {outer, inner} pair.
  - Filter register `filt` holds the accepted pair.
  - A stability counter resets whenever the synced pair equals `filt` or changed since the previous cycle; otherwise it increments.
  - When the counter equals DEBOUNCE−1 and the synced pair still differs from `filt`, `filt` loads the synced pair.
  - Pulses shorter than DEBOUNCE cycles never reach the FSM.
- **Per lane FSM** on `filt` (o,i). States: IDLE, EA(10), EB(11), EC(01), XA(01), XB(11), XC(10), ERR.
  - IDLE: 10→EA; 01→XA; 11→ERR; 00 stays.
  - EA: 11→EB; 00→IDLE (abort, no pulse); 01→ERR.
  - EB: 01→EC; 10→EA (backing out); 00→ERR.
  - EC: 00→IDLE with `enter`; 11→EB; 10→ERR.
  - XA/XB/XC mirror EA/EB/EC with o and i swapped; XC 00→IDLE with `exit`.
  - ERR: stays until 00, then IDLE with no pulse.
  - `seq_err` pulses on every transition into ERR.
  - Unlisted inputs hold the current state.
- `enter`, `exit` and `seq_err` are registered; at most one of the three is high per lane per cycle.
- **Occupancy:**
  - delta = popcount(enter) − popcount(exit), computed over all lanes in the same cycle.
  - Next count = clamp(count + delta, 0, CAP).
  - Excess entries that are clamped set `ovf`; excess exits that are clamped set `unf`.
  - Arithmetic uses CNT_W+$clog2(N_LANES)+2 signed bits, so no intermediate wrap.
- `clear` has priority: count←0, `ovf`/`unf`←0, and any same-cycle delta is discarded. `clear` does not affect lane FSMs or filters.
- `full` and `empty` are decoded combinationally from the `count` register.

## Timing
- **Reset (async assert, sync deassert handled externally):**
  - Synchronisers, `filt` and stability counters cleared to 0; FSMs to IDLE.
  - `enter`/`exit`/`seq_err` = 0, `count` = 0, `ovf`/`unf` = 0.
  - Hence `empty` = 1 and `full` = 0.
  - Reset mid-sequence discards the partial car.
- **Latency:**
  - Raw change sampled at edge k → synced pair valid after edge k+1.
  - `filt` updates at edge k+1+DEBOUNCE.
  - FSM state and pulse register update at edge k+2+DEBOUNCE.
  - `count` updates at edge k+3+DEBOUNCE.
- Pulses are exactly one cycle wide. Back-to-back cars on one lane are limited by the debounce rate only.
- Simultaneous events: N entries and N exits in one cycle net to zero change; no `ovf`/`unf` unless the clamp actually triggers.
- At count == CAP with an entry and an exit in the same cycle: net 0, count unchanged, `ovf` stays 0.

## Test plan
- **Entry, N_LANES=2, CAP=3, DEBOUNCE=2:** lane0 walks 00→10→11→01→00, each held 4 cycles → single `enter[0]` pulse 4 edges after final 00 is sampled; `count` 0→1 one edge later; `empty` falls.
- **Glitch/abort:** lane1 inner pulses high for 1 cycle → no FSM change. Then 00→10→00 → no pulses, `count` unchanged.
- **Illegal sequence:** lane0 00→11 → `seq_err[0]` pulse. Then 01→00 → no `enter`, FSM returns to IDLE.
- **Saturation:** 3 entries → `count`=3, `full`=1. 4th entry → `count` stays 3, `ovf`=1. `clear` → `count`=0, `ovf`=0.
- **Concurrent lanes:** from count 1, lane0 entry and lane1 exit pulse in the same cycle → `count` stays 1. Then two exits in the same cycle → `count`=0, `unf`=1.
- **Async reset:** assert `reset_n`=0 while lane0 is in EB → outputs immediately zero. After release, completing 01→00 produces no `enter`.
